// File: rtl/neo_d0_pkg.sv
// ============================================================================
//  Module      : neo_d0_pkg
//  Description : Shared types and constants for the NEO-D0 clock-enable
//                sequencer. Optional macro CLKSEQ_1M5_EN widens the frame
//                divider to 4 bits (16-cycle frame, adds a 1.5 MHz enable).
//  Contents    : clkseq_state_t, DIV_W, FRAME_LAST, RESET_PHASE_DEFAULT
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package neo_d0_pkg;

`ifdef CLKSEQ_1M5_EN
    localparam int DIV_W = 4;
`else
    localparam int DIV_W = 3;
`endif

    // Last divider value of a frame; the divider wraps from here to 0.
    localparam logic [DIV_W-1:0] FRAME_LAST = '1;

    // Divider phase loaded at reset and when leaving start-up.
    localparam logic [2:0] RESET_PHASE_DEFAULT = 3'd4;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2
    } clkseq_state_t;

endpackage

`default_nettype wire

// File: rtl/clkseq_div.sv
// ============================================================================
//  Module      : clkseq_div
//  Description : Frame divider for the clock-enable sequencer, with
//                load/clear/increment controls and the enable decode.
//                CLKSEQ_1M5_EN adds the o_en_1m5 output.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                i_load/i_clr/i_inc - divider controls (priority in that order)
//                i_run              - registered RUN-state qualifier
//                o_div              - current divider value
//                o_en_*             - clock enables, 0 unless i_run
//                o_frame_start      - RUN cycle with divider at 0
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkseq_div
    import neo_d0_pkg::*;
#(
    parameter logic [DIV_W-1:0] LOAD_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_run,
    output logic [DIV_W-1:0] o_div,
    output logic             o_en_12m,
    output logic             o_en_6m,
    output logic             o_en_3m,
`ifdef CLKSEQ_1M5_EN
    output logic             o_en_1m5,
`endif
    output logic             o_frame_start
);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= LOAD_VAL;
        end else if (i_load) begin
            r_div <= LOAD_VAL;
        end else if (i_clr) begin
            r_div <= '0;
        end else if (i_inc) begin
            r_div <= (r_div == FRAME_LAST) ? '0 : r_div + DIV_W'(1);
        end
    end

    // Pure decodes of registered state: no input reaches these combinationally.
    assign o_div         = r_div;
    assign o_en_12m      = i_run & r_div[0];
    assign o_en_6m       = i_run & (r_div[1:0] == 2'b11);
    assign o_en_3m       = i_run & (r_div[2:0] == 3'b111);
`ifdef CLKSEQ_1M5_EN
    assign o_en_1m5      = i_run & (r_div == FRAME_LAST);
`endif
    assign o_frame_start = i_run & (r_div == '0);

endmodule

`default_nettype wire

// File: rtl/clk_enable_sequencer.sv
// ============================================================================
//  Module      : clk_enable_sequencer
//  Description : Sequences the CLK_24M-derived clock enables (12M/6M/3M and,
//                with macro CLKSEQ_1M5_EN, 1.5M). Holds all enables off for
//                STARTUP_CYCLES+1 edges after reset, then runs; grants a
//                frame-aligned freeze through the HOLD_REQ/HOLD_ACK handshake.
//  Ports       : CLK_24M     in  - only clock
//                nRESETP     in  - async active-low reset
//                HOLD_REQ    in  - level request to freeze at frame boundary
//                HOLD_ACK    out - frozen (HOLD state)
//                EN_12M/6M/3M out - 1-cycle enables
//                EN_1M5      out - only with CLKSEQ_1M5_EN
//                FRAME_START out - RUN cycle with divider at 0
//                RUNNING     out - RUN state
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_enable_sequencer
    import neo_d0_pkg::*;
#(
    parameter logic [2:0] RESET_PHASE    = RESET_PHASE_DEFAULT,
    parameter logic [7:0] STARTUP_CYCLES = 8'd16
) (
    input  logic CLK_24M,
    input  logic nRESETP,
    input  logic HOLD_REQ,
    output logic HOLD_ACK,
    output logic EN_12M,
    output logic EN_6M,
    output logic EN_3M,
`ifdef CLKSEQ_1M5_EN
    output logic EN_1M5,
`endif
    output logic FRAME_START,
    output logic RUNNING
);

    clkseq_state_t    r_state;
    clkseq_state_t    w_state_nxt;
    logic [7:0]       r_cnt;
    logic [DIV_W-1:0] w_div;
    logic             w_div_load;
    logic             w_div_clr;
    logic             w_div_inc;
    logic             w_run;

    always_ff @(posedge CLK_24M or negedge nRESETP) begin
        if (!nRESETP) begin
            r_state <= ST_STARTUP;
            r_cnt   <= STARTUP_CYCLES;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_STARTUP && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // HOLD is only granted on the last cycle of a frame, so a frame in
    // progress always completes and a request dropped earlier just lapses.
    always_comb begin
        w_state_nxt = r_state;
        w_div_load  = 1'b0;
        w_div_clr   = 1'b0;
        w_div_inc   = 1'b0;
        case (r_state)
            ST_STARTUP: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_RUN;
                    w_div_load  = 1'b1;
                end
            end
            ST_RUN: begin
                w_div_inc = 1'b1;
                if (HOLD_REQ && (w_div == FRAME_LAST)) begin
                    w_state_nxt = ST_HOLD;
                    w_div_clr   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!HOLD_REQ) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_STARTUP;
            end
        endcase
    end

    assign w_run    = (r_state == ST_RUN);
    assign RUNNING  = w_run;
    assign HOLD_ACK = (r_state == ST_HOLD);

    clkseq_div #(
        .LOAD_VAL (DIV_W'(RESET_PHASE))
    ) u_div (
        .clk           (CLK_24M),
        .rst_n         (nRESETP),
        .i_load        (w_div_load),
        .i_clr         (w_div_clr),
        .i_inc         (w_div_inc),
        .i_run         (w_run),
        .o_div         (w_div),
        .o_en_12m      (EN_12M),
        .o_en_6m       (EN_6M),
        .o_en_3m       (EN_3M),
`ifdef CLKSEQ_1M5_EN
        .o_en_1m5      (EN_1M5),
`endif
        .o_frame_start (FRAME_START)
    );

endmodule

`default_nettype wire

// File: tb/tb_clk_enable_sequencer.sv
// ============================================================================
//  Module      : tb_clk_enable_sequencer
//  Description : Scoreboard bench for clk_enable_sequencer. Stimulus pushes
//                the hand-derived output vector for each cycle; a negedge
//                monitor pops and compares. Honours CLKSEQ_1M5_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_enable_sequencer;

`ifdef CLKSEQ_1M5_EN
    localparam int FL  = 15;
    localparam int SC  = 0;
    localparam bit OPT = 1'b1;
`else
    localparam int FL  = 7;
    localparam int SC  = 16;
    localparam bit OPT = 1'b0;
`endif

    // {ack, running, frame_start, en12, en6, en3, en1m5}
    typedef logic [6:0] vec_t;
    localparam vec_t V_IDLE = 7'b000_0000;
    localparam vec_t V_HOLD = 7'b100_0000;

    logic clk;
    logic rst_n;
    logic hold_req;
    logic hold_ack, en12, en6, en3, fstart, running;
    logic en1m5;

    int   checks = 0;
    int   errors = 0;
    int   c12 = 0, c6 = 0, c3 = 0, c15 = 0;
    int   exp_d = 0;
    vec_t q[$];

    clk_enable_sequencer #(
        .RESET_PHASE    (3'd4),
        .STARTUP_CYCLES (8'(SC))
    ) dut (
        .CLK_24M     (clk),
        .nRESETP     (rst_n),
        .HOLD_REQ    (hold_req),
        .HOLD_ACK    (hold_ack),
        .EN_12M      (en12),
        .EN_6M       (en6),
        .EN_3M       (en3),
`ifdef CLKSEQ_1M5_EN
        .EN_1M5      (en1m5),
`endif
        .FRAME_START (fstart),
        .RUNNING     (running)
    );

`ifndef CLKSEQ_1M5_EN
    assign en1m5 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t sample();
        return {hold_ack, running, fstart, en12, en6, en3, en1m5};
    endfunction

    // Expected outputs in RUN for a given divider value.
    function automatic vec_t run_vec(input int d);
        vec_t v;
        v    = '0;
        v[5] = 1'b1;
        v[4] = (d == 0);
        v[3] = (d % 2 == 1);
        v[2] = (d % 4 == 3);
        v[1] = (d % 8 == 7);
        v[0] = OPT && (d == 15);
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    // Outputs of the cycle following the next edge are e; req is applied
    // during that cycle.
    task automatic cyc(input bit req, input vec_t e);
        @(posedge clk);
        #1;
        hold_req = req;
        q.push_back(e);
    endtask

    task automatic run_n(input int n, input bit req);
        for (int i = 0; i < n; i++) begin
            cyc(req, run_vec(exp_d));
            exp_d = (exp_d + 1) % (FL + 1);
        end
    endtask

    task automatic run_until(input int t);
        for (int i = 0; i <= FL && exp_d != t; i++) run_n(1, 1'b0);
        chk("phase_reached", exp_d, t);
    endtask

    task automatic release_reset(input bit req);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        hold_req = req;
        q.push_back(V_IDLE);
        for (int i = 0; i < SC; i++) cyc(req, V_IDLE);
        exp_d = 4;
    endtask

    // Monitor: every cycle with an expectation queued is compared.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            vec_t e, a;
            e = q.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%b exp=%b (ack,run,fs,12,6,3,1m5)",
                         $time, a, e);
            end
            c12 += int'(a[3]);
            c6  += int'(a[2]);
            c3  += int'(a[1]);
            c15 += int'(a[0]);
            if (a[1] === 1'b1) begin
                checks++;
                if (!(a[3] === 1'b1 && a[2] === 1'b1)) begin
                    errors++;
                    $display("FAIL en3_coincide t=%0t got12=%b got6=%b exp=1",
                             $time, a[3], a[2]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout t=%0t got=running exp=finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        hold_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'(sample()), 0);

        // Test 1: start-up window then RUN from phase 4
        release_reset(1'b0);
        run_n(2 * (FL + 1), 1'b0);

        // Test 2: free-run enable counts over 64 cycles
        @(negedge clk);
        #1;
        c12 = 0; c6 = 0; c3 = 0; c15 = 0;
        run_n(64, 1'b0);
        @(negedge clk);
        #1;
        chk("count_en12", c12, 32);
        chk("count_en6", c6, 16);
        chk("count_en3", c3, 8);
        chk("count_en1m5", c15, OPT ? 4 : 0);

        // Test 3: request mid-frame, frame completes, hold 10 cycles, resume
        run_until(2);
        for (int d = 2; d <= FL; d++) cyc(1'b1, run_vec(d));
        repeat (9) cyc(1'b1, V_HOLD);
        cyc(1'b0, V_HOLD);
        exp_d = 0;
        run_n(FL + 1, 1'b0);

        // Test 4: request withdrawn before the boundary is never granted
        run_until(3);
        cyc(1'b1, run_vec(3));
        cyc(1'b1, run_vec(4));
        cyc(1'b0, run_vec(5));
        exp_d = 6;
        run_n(2 * (FL + 1), 1'b0);

        // Test 5: reset while holding drops everything without an edge
        run_until(FL);
        cyc(1'b1, run_vec(FL));
        repeat (3) cyc(1'b1, V_HOLD);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_in_hold", int'(sample()), 0);
        repeat (2) cyc(1'b0, V_IDLE);

        // Request held through start-up is ignored until a RUN frame boundary
        release_reset(1'b1);
        cyc(1'b0, run_vec(4));
        exp_d = 5;
        run_n(2 * (FL + 1), 1'b0);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
